// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage.
// One transaction in flight; data wins unless fetch has waited MAX_DM_BURST data grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int MAX_DM_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              err_o
);

    // state   | meaning
    // IDLE    | no transaction outstanding, arbitrating
    // BUSY_IF | fetch read issued, waiting for mem_rvalid_i
    // BUSY_DM | data read/write issued, waiting for mem_rvalid_i
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    localparam int CNT_W = $clog2(MAX_DM_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DM_BURST);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_nxt;
    logic             dm_we_q;
    logic             err;
    logic             err_set;
    logic             dm_win;
    logic             if_win;

    assign dm_win = dm_req_i & (~if_req_i | (burst_cnt < BURST_MAX));
    assign if_win = if_req_i & ~dm_win;

    always_comb begin
        state_nxt   = state;
        burst_nxt   = burst_cnt;
        err_set     = 1'b0;
        if_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        dm_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_rdata_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        // Everything is forced quiet while reset is held, even with requests pending.
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    err_set = mem_rvalid_i;
                    if (dm_win) begin
                        dm_gnt_o    = 1'b1;
                        mem_req_o   = 1'b1;
                        mem_we_o    = dm_we_i;
                        mem_addr_o  = dm_addr_i;
                        mem_wdata_o = dm_wdata_i;
                        state_nxt   = BUSY_DM;
                        if (!if_req_i)
                            burst_nxt = '0;
                        else if (burst_cnt != BURST_MAX)
                            burst_nxt = burst_cnt + CNT_W'(1);
                    end else if (if_win) begin
                        if_gnt_o   = 1'b1;
                        mem_req_o  = 1'b1;
                        mem_addr_o = if_addr_i;
                        state_nxt  = BUSY_IF;
                        burst_nxt  = '0;
                    end
                end
                BUSY_IF: begin
                    if (mem_rvalid_i) begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = mem_rdata_i;
                        state_nxt   = IDLE;
                    end
                end
                BUSY_DM: begin
                    if (mem_rvalid_i) begin
                        dm_rvalid_o = 1'b1;
                        dm_rdata_o  = dm_we_q ? '0 : mem_rdata_i;
                        state_nxt   = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            burst_cnt <= '0;
            dm_we_q   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            err       <= err | err_set;
            if (dm_gnt_o)
                dm_we_q <= dm_we_i;
        end
    end

    assign if_stall_o = ~rst_i & if_req_i & ~if_rvalid_o;
    assign dm_stall_o = ~rst_i & dm_req_i & ~dm_rvalid_o;
    assign busy_o     = ~rst_i & (state != IDLE);
    assign err_o      = err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle memory model (rdata = addr ^ 0xA5A5).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [63:0] if_addr, dm_addr, dm_wdata;
    logic        if_gnt, if_rvalid, if_stall, dm_gnt, dm_rvalid, dm_stall;
    logic [63:0] if_rdata, dm_rdata;
    logic        mem_req, mem_we, mem_rvalid, busy, err;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic [1:0]  pend = 2'b00;
    logic [63:0] a1 = '0, a2 = '0;
    logic        spur = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_DM_BURST(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_stall_o(if_stall),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata), .dm_stall_o(dm_stall),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .err_o(err)
    );

    // Memory model is deliberately not reset, so a late response can follow a reset.
    always @(posedge clk) begin
        pend <= {pend[0], mem_req};
        a1   <= mem_addr;
        a2   <= a1;
    end
    assign mem_rvalid = pend[1] | spur;
    assign mem_rdata  = a2 ^ 64'hA5A5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    typedef struct {
        logic        if_req, dm_req, dm_we;
        logic [63:0] if_addr, dm_addr, dm_wdata;
        logic        exp_dm, exp_we;
        logic [63:0] exp_addr, exp_wdata, exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic got;
        int   lat;

        vecs[0] = '{1, 0, 0, 64'h10,  64'h0,   64'h0,    0, 0, 64'h10,  64'h0,    64'hA5B5};
        vecs[1] = '{0, 1, 1, 64'h0,   64'h40,  64'h1234, 1, 1, 64'h40,  64'h1234, 64'h0};
        vecs[2] = '{0, 1, 0, 64'h0,   64'h80,  64'h0,    1, 0, 64'h80,  64'h0,    64'hA525};
        vecs[3] = '{1, 1, 0, 64'h20,  64'h100, 64'h0,    1, 0, 64'h100, 64'h0,    64'hA4A5};
        vecs[4] = '{1, 0, 1, 64'h30,  64'h0,   64'hBEEF, 0, 0, 64'h30,  64'h0,    64'hA595};

        // Reset held with both requesters active: everything must stay quiet.
        rst = 1; idle_inputs();
        if_req = 1; dm_req = 1; if_addr = 64'h8; dm_addr = 64'h9; dm_we = 1; dm_wdata = 64'h7;
        tick(); tick();
        @(negedge clk);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_dm_gnt", dm_gnt, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stalls", {if_stall, dm_stall}, 0);
        chk("rst_busy_err", {busy, err}, 0);
        tick();
        rst = 0; idle_inputs();
        tick();

        for (int i = 0; i < 5; i++) begin
            if_req = vecs[i].if_req; dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
            if_addr = vecs[i].if_addr; dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), {dm_gnt, if_gnt}, vecs[i].exp_dm ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_mem_req", i), mem_req, 1);
            chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].exp_we);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
            got = 0; lat = 0;
            for (int w = 0; w < 8 && !got; w++) begin
                tick(); lat++;
                @(negedge clk);
                if (vecs[i].exp_dm ? dm_rvalid : if_rvalid) got = 1;
            end
            chk($sformatf("v%0d_resp_seen", i), got, 1);
            chk($sformatf("v%0d_latency", i), lat, 2);
            chk($sformatf("v%0d_rdata", i), vecs[i].exp_dm ? dm_rdata : if_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_other_rvalid", i), vecs[i].exp_dm ? if_rvalid : dm_rvalid, 0);
            tick();
            idle_inputs();
        end

        // Single fetch: stall and busy timeline.
        if_req = 1; if_addr = 64'h10;
        @(negedge clk);
        chk("sf_t0_stall_busy", {if_stall, busy}, 2'b10);
        tick();
        @(negedge clk);
        chk("sf_t1_stall_busy", {if_stall, busy}, 2'b11);
        chk("sf_t1_no_regrant", {if_gnt, mem_req}, 0);
        tick();
        @(negedge clk);
        chk("sf_t2_rvalid", if_rvalid, 1);
        chk("sf_t2_stall_busy", {if_stall, busy}, 2'b01);
        tick();
        idle_inputs();

        // Simultaneous requests with an empty burst count.
        if_req = 1; if_addr = 64'h18; dm_req = 1; dm_addr = 64'h200;
        @(negedge clk);
        chk("sim_t0_gnt", {dm_gnt, if_gnt}, 2'b10);
        tick(); tick();
        @(negedge clk);
        chk("sim_t2_dm_rvalid", dm_rvalid, 1);
        chk("sim_t2_dm_rdata", dm_rdata, 64'hA7A5);
        tick();
        dm_req = 0;
        @(negedge clk);
        chk("sim_t3_if_gnt", if_gnt, 1);
        tick(); tick();
        @(negedge clk);
        chk("sim_t5_if_rvalid", if_rvalid, 1);
        chk("sim_t5_if_rdata", if_rdata, 64'hA5BD);
        tick();
        idle_inputs();

        // Starvation bound: both held, fetch gets the 5th grant.
        if_req = 1; if_addr = 64'h28; dm_req = 1; dm_addr = 64'h300;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("starve_c%0d", k), {dm_gnt, if_gnt},
                (k == 12) ? 2'b01 : ((k % 3 == 0) ? 2'b10 : 2'b00));
            tick();
        end
        idle_inputs();
        got = 0;
        for (int w = 0; w < 6 && !got; w++) begin
            @(negedge clk);
            if (!busy) got = 1;
            else tick();
        end
        chk("starve_drain", got, 1);
        tick();

        // Reset in the middle of a data read; the late response must flag an error.
        dm_req = 1; dm_addr = 64'h60;
        @(negedge clk);
        chk("rmid_t0_dm_gnt", dm_gnt, 1);
        tick();
        rst = 1;
        #1;
        chk("rmid_busy", busy, 0);
        chk("rmid_dm_stall", dm_stall, 0);
        chk("rmid_mem_req", mem_req, 0);
        #5;
        rst = 0; idle_inputs();
        tick();
        @(negedge clk);
        chk("rmid_t2_no_rvalid", {dm_rvalid, if_rvalid}, 0);
        tick();
        chk("rmid_t3_err", err, 1);
        chk("rmid_t3_busy", busy, 0);
        if_req = 1; if_addr = 64'h50;
        @(negedge clk);
        chk("rmid_t3_if_gnt", if_gnt, 1);
        chk("rmid_t3_mem_addr", mem_addr, 64'h50);
        tick(); tick();
        @(negedge clk);
        chk("rmid_t5_if_rdata", {63'b0, if_rvalid}, 1);
        chk("rmid_t5_if_rdata_val", if_rdata, 64'hA5F5);
        tick();
        idle_inputs();

        // Spurious response while idle.
        rst = 1;
        #2;
        rst = 0;
        @(negedge clk);
        chk("spur_err_cleared", err, 0);
        tick();
        spur = 1;
        @(negedge clk);
        chk("spur_no_rvalid", {if_rvalid, dm_rvalid}, 0);
        tick();
        spur = 0;
        @(negedge clk);
        chk("spur_err_set", err, 1);
        tick(); tick(); tick();
        @(negedge clk);
        chk("spur_err_sticky", err, 1);
        rst = 1;
        #1;
        chk("spur_err_reset", err, 0);
        tick();
        rst = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
